alu_ex_stage: RTL and testbench

//  Execute pipeline stage wrapped around the combinational alu. Accepts operands, alucont and a

---
 rtl/alu_ex_stage.sv | 117 +++++++++++
 tb/tb_alu_ex_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// Execute stage: combinational ALU feeding a 2-entry in-order result buffer.
// Decode and writeback each handshake with valid/ready. in_ready never depends on out_ready.
module alu_ex_stage #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_alucont,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic [TAGW-1:0]  out_tag
);

  logic [WIDTH-1:0] w_alu_y;
  logic             w_push;
  logic             w_pop;

  logic [WIDTH-1:0] r_res  [2];
  logic             r_zero [2];
  logic [TAGW-1:0]  r_tag  [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  alu #(.WIDTH(WIDTH)) u_alu (
    .i_a       (in_a),
    .i_b       (in_b),
    .i_alucont (in_alucont),
    .o_y       (w_alu_y)
  );

  assign in_ready   = rst_n & ~flush & (r_count < 2'd2);
  assign out_valid  = (r_count != 2'd0);
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;

  assign out_result = r_res[r_rd_ptr];
  assign out_zero   = r_zero[r_rd_ptr];
  assign out_tag    = r_tag[r_rd_ptr];

  // Buffer state; flush only rewinds pointers and count, entry data survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_res[i]  <= '0;
        r_zero[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_res[r_wr_ptr]  <= w_alu_y;
        r_zero[r_wr_ptr] <= (w_alu_y == '0);
        r_tag[r_wr_ptr]  <= in_tag;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// Combinational ALU; +/- wrap, SLT is unsigned, unmapped codes yield 0.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_alucont,
  output logic [WIDTH-1:0] o_y
);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_PLS  = 3'b010;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_MNS  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  always_comb begin
    o_y = '0;
    case (i_alucont)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_PLS:  o_y = i_a + i_b;
      OP_ANDN: o_y = i_a & ~i_b;
      OP_ORN:  o_y = i_a | ~i_b;
      OP_MNS:  o_y = i_a - i_b;
      OP_SLT:  o_y = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      default: o_y = '0;
    endcase
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage with hand-computed expected values.
module tb_alu_ex_stage;

  localparam logic [2:0] AND_OP  = 3'b000;
  localparam logic [2:0] OR_OP   = 3'b001;
  localparam logic [2:0] PLS_OP  = 3'b010;
  localparam logic [2:0] ANDN_OP = 3'b100;
  localparam logic [2:0] ORN_OP  = 3'b101;
  localparam logic [2:0] MNS_OP  = 3'b110;
  localparam logic [2:0] SLT_OP  = 3'b111;
  localparam logic [2:0] BAD_OP  = 3'b011;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [31:0] in_a, in_b, out_result;
  logic [2:0]  in_alucont;
  logic [4:0]  in_tag, out_tag;

  int n_checks = 0;
  int n_errs   = 0;

  alu_ex_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_alucont (in_alucont),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] tag);
    in_a = a; in_b = b; in_alucont = op; in_tag = tag; in_valid = 1'b1;
  endtask

  // One isolated op: push, inspect head, pop, confirm empty.
  task automatic one_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [4:0] tag, input logic [31:0] exp);
    out_ready = 1'b0;
    drive(a, b, op, tag);
    step();
    in_valid = 1'b0;
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_zero"}, out_zero, (exp == 32'd0));
    chk({name, "_tag"}, out_tag, tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({name, "_empty"}, out_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = 32'd0; in_b = 32'd0; in_alucont = 3'd0; in_tag = 5'd0;
    step();
    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    one_op("pls_wrap", 32'h7FFF_FFFF, 32'h0000_0001, PLS_OP, 5'd3, 32'h8000_0000);
    one_op("mns_eq", 32'd5, 32'd5, MNS_OP, 5'd4, 32'd0);
    one_op("slt_unsigned", 32'd5, 32'hFFFF_FFFF, SLT_OP, 5'd5, 32'd1);
    one_op("slt_false", 32'hFFFF_FFFF, 32'd5, SLT_OP, 5'd6, 32'd0);
    one_op("unmapped", 32'h1234_5678, 32'h1111_1111, BAD_OP, 5'd7, 32'd0);
    one_op("and", 32'hF0F0_1234, 32'h0FF0_FFFF, AND_OP, 5'd8, 32'h00F0_1234);
    one_op("or", 32'hF000_0000, 32'h0000_000F, OR_OP, 5'd9, 32'hF000_000F);
    one_op("andn", 32'hFFFF_0000, 32'h0F0F_0F0F, ANDN_OP, 5'd10, 32'hF0F0_0000);
    one_op("orn", 32'h0000_0000, 32'hFFFF_FFF0, ORN_OP, 5'd11, 32'h0000_000F);
    one_op("mns_wrap", 32'd0, 32'd1, MNS_OP, 5'd12, 32'hFFFF_FFFF);

    // Backpressure: two accepted, third held off, head stable.
    out_ready = 1'b0;
    drive(32'd1, 32'd1, PLS_OP, 5'd20);
    chk("bp_rdy0", in_ready, 1);
    step();
    drive(32'd2, 32'd2, PLS_OP, 5'd21);
    chk("bp_rdy1", in_ready, 1);
    step();
    drive(32'd3, 32'd3, PLS_OP, 5'd22);
    chk("bp_full_rdy", in_ready, 0);
    step();
    chk("bp_stall_tag", out_tag, 20);
    chk("bp_stall_res", out_result, 2);
    chk("bp_stall_rdy", in_ready, 0);
    step();
    chk("bp_stall_tag2", out_tag, 20);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_tag", out_tag, 21);
    chk("bp_pop1_rdy", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_pop2_tag", out_tag, 22);
    chk("bp_pop2_res", out_result, 6);
    chk("bp_pop2_valid", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // Sustained stream: one result per cycle, in order.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'(i * 100), 32'(i), PLS_OP, 5'(i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_tag", out_tag, i);
      chk("stream_res", out_result, i * 101);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", out_valid, 0);

    // Flush while full, with an op offered the same cycle.
    out_ready = 1'b0;
    drive(32'd1, 32'd2, PLS_OP, 5'd24);
    step();
    drive(32'd3, 32'd4, PLS_OP, 5'd25);
    step();
    drive(32'd5, 32'd6, PLS_OP, 5'd26);
    flush = 1'b1;
    #1;
    chk("flush_rdy", in_ready, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_rdy_after", in_ready, 1);
    step();
    chk("flush_dropped", out_valid, 0);
    one_op("post_flush", 32'd40, 32'd2, PLS_OP, 5'd27, 32'd42);

    // Reset while full.
    out_ready = 1'b0;
    drive(32'd7, 32'd1, PLS_OP, 5'd30);
    step();
    drive(32'd8, 32'd1, PLS_OP, 5'd31);
    step();
    in_valid = 1'b0;
    chk("full_rdy", in_ready, 0);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_result", out_result, 0);
    chk("mid_rst_zero", out_zero, 0);
    chk("mid_rst_tag", out_tag, 0);
    chk("mid_rst_rdy", in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_rdy_after", in_ready, 1);
    step();
    chk("mid_rst_still_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
